// File: rtl/axi_default_slave.sv
// ---------------------------------------------------------------------------
// axi_default_slave
//
// AXI4 default responder. The interconnect routes a transaction here when no
// real slave decodes its address; every such transaction is completed with a
// DECERR response so the master never stalls waiting for a reply.
//
// Write and read channels are served by two independent state machines, each
// allowing a single outstanding transaction. A saturating count of completed
// error transactions (B handshakes plus final R handshakes) is exposed for
// debug/status.
//
// Parameters
//   ID_WIDTH   - width of AWID/BID/ARID/RID
//   DATA_WIDTH - width of WDATA/RDATA
//   CNT_WIDTH  - width of ERR_COUNT
//
// Ports
//   ACLK, ARESETn                  - clock (rising edge), async active-low reset
//   AW*: AWVALID/AWREADY/AWID/AWLEN - write address channel (AWLEN unused)
//   W* : WVALID/WREADY/WDATA/WLAST  - write data channel (data discarded)
//   B* : BVALID/BREADY/BID/BRESP    - write response channel (always DECERR)
//   AR*: ARVALID/ARREADY/ARID/ARLEN - read address channel
//   R* : RVALID/RREADY/RID/RDATA/RRESP/RLAST - read data (zero data, DECERR)
//   ERR_COUNT                       - saturating completed-error counter
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module axi_default_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [7:0]            AWLEN,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [7:0]            ARLEN,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic [CNT_WIDTH-1:0]  ERR_COUNT
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0] w_state;
  logic       r_state;
  // Beats still to deliver after the one currently presented on R.
  logic [7:0] r_beats;

  logic       b_done;
  logic       r_done;
  logic [1:0] done_inc;

  // The burst length on the write side is irrelevant (WLAST terminates the
  // burst) and write data is thrown away.
  logic unused_inputs;
  assign unused_inputs = ^{AWLEN, WDATA};

  // Saturating add of a 0/1/2 increment; a +2 from max-1 lands on max.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] base,
    input logic [1:0]           inc
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, base} + {{(CNT_WIDTH-1){1'b0}}, inc};
    if (sum[CNT_WIDTH])
      return {CNT_WIDTH{1'b1}};
    else
      return sum[CNT_WIDTH-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Write channel: accept AW, drain W until WLAST, then hold B until taken.
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_DECERR;
    end else begin
      BRESP <= RESP_DECERR;
      case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            BID     <= AWID;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          // Every beat is discarded; only the WLAST beat ends the burst.
          if (WVALID && WREADY && WLAST) begin
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BVALID && BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: begin
          AWREADY <= 1'b1;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read channel: accept AR, return ARLEN+1 zero beats with DECERR.
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      r_beats <= '0;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_DECERR;
    end else begin
      RDATA <= '0;
      RRESP <= RESP_DECERR;
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            RID     <= ARID;
            r_beats <= ARLEN;
            RVALID  <= 1'b1;
            RLAST   <= (ARLEN == 8'd0);
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RVALID && RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              // The counter never wraps: RLAST ends the burst before it
              // could be decremented below zero.
              r_beats <= r_beats - 8'd1;
              RLAST   <= (r_beats == 8'd1);
            end
          end
        end
        default: begin
          ARREADY <= 1'b1;
          RVALID  <= 1'b0;
          RLAST   <= 1'b0;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Completed-transaction counter (B and final R may complete together).
  // -------------------------------------------------------------------------
  assign b_done   = BVALID && BREADY;
  assign r_done   = RVALID && RREADY && RLAST;
  assign done_inc = {b_done && r_done, b_done ^ r_done};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      ERR_COUNT <= '0;
    else
      ERR_COUNT <= sat_add(ERR_COUNT, done_inc);
  end

endmodule

// File: tb/tb_axi_default_slave.sv
module tb_axi_default_slave;

  localparam int IDW  = 4;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          AWVALID, AWREADY;
  logic [IDW-1:0] AWID;
  logic [7:0]    AWLEN;
  logic          WVALID, WREADY;
  logic [DW-1:0] WDATA;
  logic          WLAST;
  logic          BVALID, BREADY;
  logic [IDW-1:0] BID;
  logic [1:0]    BRESP;
  logic          ARVALID, ARREADY;
  logic [IDW-1:0] ARID;
  logic [7:0]    ARLEN;
  logic          RVALID, RREADY;
  logic [IDW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic [CW-1:0] ERR_COUNT;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;

  always #5 ACLK = ~ACLK;

  axi_default_slave #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .ERR_COUNT(ERR_COUNT)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic idle_inputs();
    AWVALID = 0; AWID = '0; AWLEN = '0;
    WVALID = 0; WDATA = '0; WLAST = 0;
    BREADY = 0;
    ARVALID = 0; ARID = '0; ARLEN = '0;
    RREADY = 0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_awready"}, AWREADY, 1);
    chk({pfx, "_arready"}, ARREADY, 1);
    chk({pfx, "_wready"},  WREADY, 0);
    chk({pfx, "_bvalid"},  BVALID, 0);
    chk({pfx, "_rvalid"},  RVALID, 0);
    chk({pfx, "_rlast"},   RLAST, 0);
    chk({pfx, "_bid"},     BID, 0);
    chk({pfx, "_rid"},     RID, 0);
    chk({pfx, "_rdata"},   RDATA, 0);
    chk({pfx, "_errcnt"},  ERR_COUNT, 0);
    chk({pfx, "_bresp"},   BRESP, 2'b11);
    chk({pfx, "_rresp"},   RRESP, 2'b11);
  endtask

  // Runs one write and/or one read to completion. Called at posedge+1.
  // rmode: 0 RREADY always high, 1 toggling starting high, 2 random.
  // sync: hold BREADY/RREADY until both the response and the final read
  // beat are visible, so the two completions land on the same edge.
  task automatic run_txn(input bit do_wr, input int wbeats, input logic [IDW-1:0] awid,
                         input bit do_rd, input logic [7:0] arlen, input logic [IDW-1:0] arid,
                         input int rmode, input bit wgap, input int bdelay, input bit sync);
    bit aw_done, wl_done, b_done, ar_done, r_done;
    bit aw_prev, wl_prev, b_prev, ar_prev, rl_prev, w_hs, r_hs, tog;
    int wsent, rgot, bwait, cyc;
    aw_done = !do_wr; wl_done = !do_wr; b_done = !do_wr;
    ar_done = !do_rd; r_done = !do_rd;
    aw_prev = 0; wl_prev = 0; b_prev = 0; ar_prev = 0; rl_prev = 0;
    wsent = 0; rgot = 0; bwait = 0; cyc = 0; tog = 1;
    while (cyc < 2000) begin
      if (aw_prev) begin chk("wready_after_aw", WREADY, 1); chk("awready_low", AWREADY, 0); end
      if (wl_prev) begin
        chk("bvalid_after_wlast", BVALID, 1); chk("wready_off", WREADY, 0);
        chk("bid", BID, awid); chk("bresp", BRESP, 2'b11);
      end
      if (b_prev) begin chk("bvalid_off", BVALID, 0); chk("awready_back", AWREADY, 1); end
      if (ar_prev) begin chk("rvalid_after_ar", RVALID, 1); chk("arready_low", ARREADY, 0); end
      if (rl_prev) begin
        chk("rvalid_off", RVALID, 0); chk("rlast_off", RLAST, 0); chk("arready_back", ARREADY, 1);
      end
      if (do_wr && !aw_done) chk("wready_pre_aw", WREADY, 0);
      if (do_wr && aw_done && !b_done) chk("awready_busy", AWREADY, 0);
      if (do_wr && wl_done && !b_done) chk("bvalid_hold", BVALID, 1);
      if (do_rd && ar_done && !r_done) begin
        chk("rvalid_hold", RVALID, 1); chk("rid", RID, arid);
        chk("rdata", RDATA, 0); chk("rresp", RRESP, 2'b11);
        chk("rlast", RLAST, (rgot == int'(arlen)));
        chk("arready_busy", ARREADY, 0);
      end
      chk("err_count", ERR_COUNT, model_cnt);
      if (b_done && r_done) break;

      AWVALID = do_wr && !aw_done; AWID = awid; AWLEN = 8'(wbeats - 1);
      WVALID = do_wr && !wl_done && (!wgap || ($urandom_range(0, 1) == 1));
      WLAST = (wsent == wbeats - 1); WDATA = $urandom;
      ARVALID = do_rd && !ar_done; ARID = arid; ARLEN = arlen;
      if (BVALID) bwait++;
      if (sync) begin
        RREADY = BVALID;
        BREADY = RVALID && RLAST;
      end else begin
        case (rmode)
          0: RREADY = 1;
          1: RREADY = tog;
          default: RREADY = ($urandom_range(0, 1) == 1);
        endcase
        BREADY = BVALID && (bwait > bdelay);
      end
      if (RVALID) tog = ~tog;

      aw_prev = AWVALID && AWREADY;
      w_hs    = WVALID && WREADY;
      wl_prev = w_hs && WLAST;
      b_prev  = BVALID && BREADY;
      ar_prev = ARVALID && ARREADY;
      r_hs    = RVALID && RREADY;
      rl_prev = r_hs && RLAST;
      if (aw_prev) aw_done = 1;
      if (w_hs) wsent++;
      if (wl_prev) wl_done = 1;
      if (b_prev) b_done = 1;
      if (ar_prev) ar_done = 1;
      if (r_hs) rgot++;
      if (rl_prev) r_done = 1;
      model_cnt = sat(model_cnt + int'(b_prev) + int'(rl_prev));
      @(posedge ACLK); #1;
      cyc++;
    end
    chk("txn_complete", b_done && r_done, 1);
    if (do_wr) chk("w_beats", wsent, wbeats);
    if (do_rd) chk("r_beats", rgot, int'(arlen) + 1);
    idle_inputs();
  endtask

  task automatic rand_txn(input bit allow_both);
    bit w, r;
    w = 1'($urandom_range(0, 1));
    r = allow_both ? 1'($urandom_range(0, 1)) : !w;
    if (!w && !r) w = 1;
    run_txn(w, $urandom_range(1, 6), 4'($urandom), r, 8'($urandom_range(0, 5)), 4'($urandom),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
  endtask

  initial begin
    idle_inputs();
    ARESETn = 0;
    #12;
    chk_reset_vals("por");
    @(posedge ACLK); #1;
    ARESETn = 1;
    @(posedge ACLK); #1;

    // single write, AWID=5, one beat
    run_txn(1, 1, 4'h5, 0, 8'd0, 4'h0, 0, 0, 0, 0);
    chk("cnt_after_write", ERR_COUNT, 1);
    // read ARID=A, ARLEN=3, RREADY toggling
    run_txn(0, 1, 4'h0, 1, 8'd3, 4'hA, 1, 0, 0, 0);
    chk("cnt_after_read", ERR_COUNT, 2);
    // 8-beat write with W gaps and BREADY held off 5 cycles
    run_txn(1, 8, 4'h3, 0, 8'd0, 4'h0, 0, 1, 5, 0);
    chk("cnt_after_burst", ERR_COUNT, 3);
    // coinciding B and final R
    run_txn(1, 1, 4'h7, 1, 8'd0, 4'hC, 0, 0, 0, 1);
    chk("cnt_dual_inc", ERR_COUNT, 5);

    // single-direction transactions up to max-1, then a dual completion
    while (model_cnt < CMAX - 1) rand_txn(0);
    chk("cnt_at_14", ERR_COUNT, 14);
    run_txn(1, 1, 4'h2, 1, 8'd0, 4'h4, 0, 0, 0, 1);
    chk("cnt_sat_dual", ERR_COUNT, CMAX);
    for (int i = 0; i < 6; i++) rand_txn(1);
    chk("cnt_stays_sat", ERR_COUNT, CMAX);

    // reset in the middle of a 4-beat read and in W_DATA
    AWVALID = 1; AWID = 4'h9; ARVALID = 1; ARID = 4'h6; ARLEN = 8'd3; RREADY = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; ARVALID = 0;
    @(posedge ACLK); #1;
    chk("pre_rst_wready", WREADY, 1);
    chk("pre_rst_rvalid", RVALID, 1);
    chk("pre_rst_bid", BID, 4'h9);
    chk("pre_rst_rid", RID, 4'h6);
    #2 ARESETn = 0;
    #1 chk_reset_vals("mid");
    idle_inputs();
    model_cnt = 0;
    @(posedge ACLK); @(posedge ACLK); #3;
    ARESETn = 1;
    @(posedge ACLK); #1;
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_arready", ARREADY, 1);
    run_txn(0, 1, 4'h0, 1, 8'd0, 4'hB, 0, 0, 0, 0);
    chk("cnt_after_rst_read", ERR_COUNT, 1);

    // full-length read and a longer random mix
    run_txn(1, 12, 4'hE, 1, 8'd255, 4'h1, 2, 1, 2, 0);
    chk("cnt_after_long", ERR_COUNT, 3);
    for (int i = 0; i < 10; i++) rand_txn(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
